// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU; result = {remainder, quotient}.
// Optional macro DIV_ITER_EARLY_EXIT_EN: finish in 2 cycles when |dividend| < |divisor|.
module div_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   dvd, dvs, rem, op1_raw;
  logic [CNT_W-1:0]   cnt;
  logic               sign_q, sign_r;
  logic               load, fin;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   rem_step, dvd_step, q_fix, r_fix, zero_q;
  logic [2*WIDTH-1:0] fin_val;
`ifdef DIV_ITER_EARLY_EXIT_EN
  logic               early;
`endif

  assign abs_a = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign abs_b = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // One restoring step: shift {rem, dvd} left, trial-subtract the divisor.
  assign rem_sh   = {rem, dvd[WIDTH-1]};
  assign ge       = rem_sh >= {1'b0, dvs};
  assign rem_step = ge ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
  assign dvd_step = {dvd[WIDTH-2:0], ge};
  assign q_fix    = sign_q ? -dvd_step : dvd_step;
  assign r_fix    = sign_r ? -rem_step : rem_step;

`ifdef DIV_ITER_EARLY_EXIT_EN
  assign zero_q = early ? '0 : '1;
`else
  assign zero_q = '1;
`endif

  assign ready = (state == END);
  assign stall = rst & ~annul & ((state == IDLE && start) || state == ON || state == ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // The result register is written on the edge entering END, so it is valid while ready=1.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    fin     = 1'b0;
    fin_val = {r_fix, q_fix};
    case (state)
      IDLE: begin
        if (start && !annul) begin
          load = 1'b1;
          if (opdata2 == '0)
            state_n = ZERO;
`ifdef DIV_ITER_EARLY_EXIT_EN
          else if (abs_a < abs_b)
            state_n = ZERO;
`endif
          else
            state_n = ON;
        end
      end
      ZERO: begin
        fin_val = {op1_raw, zero_q};
        if (annul) state_n = IDLE;
        else begin
          state_n = END;
          fin     = 1'b1;
        end
      end
      ON: begin
        if (annul) state_n = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1)) begin
          state_n = END;
          fin     = 1'b1;
        end
      end
      END:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      op1_raw <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      result  <= '0;
`ifdef DIV_ITER_EARLY_EXIT_EN
      early   <= 1'b0;
`endif
    end else begin
      if (load) begin
        dvd     <= abs_a;
        dvs     <= abs_b;
        rem     <= '0;
        op1_raw <= opdata1;
        cnt     <= '0;
        sign_q  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
        sign_r  <= signed_div & opdata1[WIDTH-1];
`ifdef DIV_ITER_EARLY_EXIT_EN
        early   <= (opdata2 != '0);
`endif
      end else if (state == ON) begin
        rem <= rem_step;
        dvd <= dvd_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (fin) result <= fin_val;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: driver pushes expected {result, latency}, monitor checks on ready.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

`ifdef DIV_ITER_EARLY_EXIT_EN
  localparam int EE_LAT = 2;
`else
  localparam int EE_LAT = 33;
`endif

  typedef struct {
    logic [63:0] res;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  div_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div(signed_div), .opdata1(opdata1),
    .opdata2(opdata2), .start(start), .annul(annul), .result(result),
    .ready(ready), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && ready) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ready", {63'b0, ready}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  task automatic do_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input bit drop);
    bit got;
    @(negedge clk);
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    sb_q.push_back('{exp, cyc, lat});
    #1 chk("stall_c0", {63'b0, stall}, 64'd1);
    got = 1'b0;
    for (int i = 1; i <= lat + 5 && !got; i++) begin
      @(negedge clk);
      if (i == 1 && drop) begin
        start      = 1'b0;
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = ~sd;
      end
      #1;
      if (ready) begin
        got = 1'b1;
        chk("stall_end", {63'b0, stall}, 64'd0);
        start = 1'b0;
      end else if (i < lat) begin
        chk("stall_busy", {63'b0, stall}, 64'd1);
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got no ready expected ready within %0d cycles", lat + 5);
      start = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with start high to confirm stall is gated by reset.
    start = 1'b1;
    #12;
    chk("rst_result", result, 64'd0);
    chk("rst_ready", {63'b0, ready}, 64'd0);
    chk("rst_stall", {63'b0, stall}, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    do_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);
    do_op(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);
    do_op(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33, 1'b0);
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 1'b0);
    do_op(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 2, 1'b0);
    do_op(1'b1, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 2, 1'b0);
    do_op(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33, 1'b0);
    do_op(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 33, 1'b0);
    do_op(1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, EE_LAT, 1'b0);
    do_op(1'b1, 32'hFFFFFFFD, 32'd10, {32'hFFFFFFFD, 32'd0}, EE_LAT, 1'b0);
    do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}, EE_LAT, 1'b0);
    // Inputs change after capture: operands are latched.
    do_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b1);

    // Annul at cycle 10 of 1000/3: no ready, result keeps {2,14}.
    @(negedge clk);
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start      = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1 chk("annul_stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    #1 chk("annul_idle_stall", {63'b0, stall}, 64'd0);
    repeat (40) @(negedge clk);
    chk("annul_result_kept", result, {32'd2, 32'd14});
    do_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0);

    // Asynchronous reset in the middle of ON.
    @(negedge clk);
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start   = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", {63'b0, ready}, 64'd0);
    chk("arst_stall", {63'b0, stall}, 64'd0);
    chk("arst_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
